// File: rtl/clock_gate_array_pkg.sv
//------------------------------------------------------------------------------
// Module   : clock_gate_array_pkg
// Brief    : Shared state encoding and counter sizing for clock_gate_array.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clock_gate_array_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_e;

    // Counter must hold the larger of the two reload values
    function automatic int calc_cnt_w(input int hold_cyc, input int wake_cyc);
        int max_cyc;
        max_cyc = (hold_cyc > wake_cyc) ? hold_cyc : wake_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_gate_chan.sv
//------------------------------------------------------------------------------
// Module   : clock_gate_chan
// Brief    : One gated channel: idle/hold-off FSM, wake counter, latch gate cell.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_gate_chan
    import clock_gate_array_pkg::*;
#(
    parameter int HOLD_CYC = 8,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic te_i,
    input  logic req_i,
    input  logic idle_i,
    output logic ack_o,
    output logic gated_o,
    output logic clk_o
);

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_wake_load = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    cg_state_e        r_state;
    cg_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_qual;
    logic             w_en;
    logic             r_latch;

    assign w_qual = !req_i && idle_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The RUN cycle that spots idle counts as the first of HOLD_CYC, so DRAIN
    // lasts HOLD_CYC-1 cycles and exits on cnt==1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            RUN: begin
                if (w_qual) begin
                    if (HOLD_CYC == 1) begin
                        w_state_nxt = GATED;
                    end else begin
                        w_state_nxt = DRAIN;
                        w_cnt_nxt   = c_hold_load;
                    end
                end
            end
            DRAIN: begin
                if (!w_qual) begin
                    w_state_nxt = RUN;
                end else if (r_cnt <= c_cnt_one) begin
                    w_state_nxt = GATED;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            GATED: begin
                if (req_i) begin
                    w_state_nxt = WAKE;
                    w_cnt_nxt   = c_wake_load;
                end
            end
            WAKE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign ack_o   = (r_state == RUN) || (r_state == DRAIN);
    assign gated_o = (r_state == GATED);
    assign w_en    = (r_state != GATED);

    // Enable only moves on the rising edge, while this latch is opaque
    always_latch begin
        if (!clk_i) begin
            r_latch <= w_en | te_i;
        end
    end

    assign clk_o = r_latch & clk_i;

endmodule

`default_nettype wire

// File: rtl/clock_gate_array.sv
//------------------------------------------------------------------------------
// Module   : clock_gate_array
// Brief    : NUM_CH independent clock-gate channels; optional gated-cycle stats
//            enabled by CLOCK_GATE_ARRAY_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_gate_array
    import clock_gate_array_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int HOLD_CYC = 8,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = calc_cnt_w(HOLD_CYC, WAKE_CYC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              te_i,
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] idle_i,
    output logic [NUM_CH-1:0] ack_o,
    output logic [NUM_CH-1:0] gated_o,
    output logic [NUM_CH-1:0] clk_o
`ifdef CLOCK_GATE_ARRAY_STATS_EN
    ,
    input  logic                 stats_clr_i,
    output logic [NUM_CH*32-1:0] gated_cnt_o
`endif
);

    logic [NUM_CH-1:0] w_gated;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        clock_gate_chan #(
            .HOLD_CYC (HOLD_CYC),
            .WAKE_CYC (WAKE_CYC),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .te_i    (te_i),
            .req_i   (req_i[g]),
            .idle_i  (idle_i[g]),
            .ack_o   (ack_o[g]),
            .gated_o (w_gated[g]),
            .clk_o   (clk_o[g])
        );
    end

    assign gated_o = w_gated;

`ifdef CLOCK_GATE_ARRAY_STATS_EN
    for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
        logic [31:0] r_gated_cnt;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_gated_cnt <= '0;
            end else if (stats_clr_i) begin
                r_gated_cnt <= '0;
            end else if (w_gated[g] && (r_gated_cnt != 32'hFFFF_FFFF)) begin
                r_gated_cnt <= r_gated_cnt + 32'd1;
            end
        end

        assign gated_cnt_o[g*32 +: 32] = r_gated_cnt;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_gate_array.sv
//------------------------------------------------------------------------------
// Module   : tb_clock_gate_array
// Brief    : Self-checking bench for clock_gate_array (NUM_CH=4, HOLD=4, WAKE=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_clock_gate_array;

    localparam int NUM_CH   = 4;
    localparam int HOLD_CYC = 4;
    localparam int WAKE_CYC = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              te_i;
    logic [NUM_CH-1:0] req_i;
    logic [NUM_CH-1:0] idle_i;
    logic [NUM_CH-1:0] ack_o;
    logic [NUM_CH-1:0] gated_o;
    logic [NUM_CH-1:0] clk_o;
`ifdef CLOCK_GATE_ARRAY_STATS_EN
    logic                 stats_clr_i;
    logic [NUM_CH*32-1:0] gated_cnt_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    clock_gate_array #(
        .NUM_CH   (NUM_CH),
        .HOLD_CYC (HOLD_CYC),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .te_i    (te_i),
        .req_i   (req_i),
        .idle_i  (idle_i),
        .ack_o   (ack_o),
        .gated_o (gated_o),
        .clk_o   (clk_o)
`ifdef CLOCK_GATE_ARRAY_STATS_EN
        ,
        .stats_clr_i (stats_clr_i),
        .gated_cnt_o (gated_cnt_o)
`endif
    );

    typedef struct packed {
        logic [NUM_CH-1:0] ack;
        logic [NUM_CH-1:0] gated;
    } exp_t;

    typedef struct {
        logic [NUM_CH-1:0] req;
        logic [NUM_CH-1:0] idle;
        logic              te;
        int                ncyc;
        logic [NUM_CH-1:0] ack;
        logic [NUM_CH-1:0] gated;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[$];

    int   m_qcnt  [NUM_CH];
    int   m_wake  [NUM_CH];
    logic m_gated [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: count consecutive qualifying cycles, gate on the HOLD_CYC-th,
    // and hold ack low for WAKE_CYC further edges after the waking edge.
    function automatic void model_step(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] idle);
        exp_t e;
        for (int c = 0; c < NUM_CH; c++) begin
            if (m_gated[c]) begin
                if (req[c]) begin
                    m_gated[c] = 1'b0;
                    m_wake[c]  = WAKE_CYC;
                end
            end else if (m_wake[c] > 0) begin
                m_wake[c]--;
                m_qcnt[c] = 0;
            end else if (!req[c] && idle[c]) begin
                m_qcnt[c]++;
                if (m_qcnt[c] == HOLD_CYC) begin
                    m_gated[c] = 1'b1;
                    m_qcnt[c]  = 0;
                end
            end else begin
                m_qcnt[c] = 0;
            end
            e.ack[c]   = !m_gated[c] && (m_wake[c] == 0);
            e.gated[c] = m_gated[c];
        end
        sb_q.push_back(e);
    endfunction

    function automatic void add(input logic [3:0] req, input logic [3:0] idle, input logic te,
                                input int n, input logic [3:0] ack, input logic [3:0] gated);
        vec_t v;
        v.req = req; v.idle = idle; v.te = te; v.ncyc = n; v.ack = ack; v.gated = gated;
        tbl.push_back(v);
    endfunction

    initial begin
        exp_t e;

        for (int c = 0; c < NUM_CH; c++) begin
            m_qcnt[c] = 0; m_wake[c] = 0; m_gated[c] = 1'b0;
        end

        //   req    idle  te    n  ack    gated
        add(4'h0, 4'h0, 1'b0, 3, 4'hF, 4'h0);
        add(4'h0, 4'h1, 1'b0, 4, 4'hE, 4'h1);
        add(4'h0, 4'h3, 1'b0, 3, 4'hE, 4'h1);
        add(4'h0, 4'h1, 1'b0, 1, 4'hE, 4'h1);
        add(4'h0, 4'h3, 1'b0, 3, 4'hE, 4'h1);
        add(4'h0, 4'h3, 1'b0, 1, 4'hC, 4'h3);
        add(4'h1, 4'h3, 1'b0, 1, 4'hC, 4'h2);
        add(4'h0, 4'h3, 1'b0, 2, 4'hD, 4'h2);
        add(4'h0, 4'h3, 1'b0, 4, 4'hC, 4'h3);
        for (int i = 0; i < 3; i++) begin
            add(4'h4, 4'hC, 1'b0, 1, 4'hC, 4'h3);
            add(4'h8, 4'hC, 1'b0, 1, 4'hC, 4'h3);
        end
        add(4'h0, 4'hC, 1'b0, 4, 4'h0, 4'hF);
        add(4'h0, 4'hC, 1'b1, 1, 4'h0, 4'hF);
        add(4'hF, 4'hC, 1'b0, 3, 4'hF, 4'h0);
        add(4'h0, 4'h0, 1'b0, 2, 4'hF, 4'h0);

        rst_i  = 1'b1;
        te_i   = 1'b0;
        req_i  = '0;
        idle_i = '0;
`ifdef CLOCK_GATE_ARRAY_STATS_EN
        stats_clr_i = 1'b0;
`endif
        tick();
        tick();
        chk("reset_ack", 32'(ack_o), 32'hF);
        chk("reset_gated", 32'(gated_o), 32'h0);
        rst_i = 1'b0;
        tick();
        chk("run_clk_high", 32'(clk_o), 32'hF);
        @(negedge clk_i); #1;
        chk("run_clk_low", 32'(clk_o), 32'h0);
        tick();

        // Table-driven phases with a per-cycle scoreboard
        for (int v = 0; v < tbl.size(); v++) begin
            req_i  = tbl[v].req;
            idle_i = tbl[v].idle;
            te_i   = tbl[v].te;
            for (int k = 0; k < tbl[v].ncyc; k++) begin
                model_step(req_i, idle_i);
                tick();
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("v%0d_c%0d_ack", v, k), 32'(ack_o), 32'(e.ack));
                    chk($sformatf("v%0d_c%0d_gated", v, k), 32'(gated_o), 32'(e.gated));
                end
            end
            chk($sformatf("v%0d_end_ack", v), 32'(ack_o), 32'(tbl[v].ack));
            chk($sformatf("v%0d_end_gated", v), 32'(gated_o), 32'(tbl[v].gated));
        end
        te_i = 1'b0; req_i = '0; idle_i = '0;

        // Ch0 gating: last pulse on the GATED edge, flat afterwards
        idle_i = 4'h1;
        repeat (4) tick();
        chk("g0_gated", 32'(gated_o[0]), 32'd1);
        chk("g0_last_pulse", 32'(clk_o[0]), 32'd1);
        tick();
        chk("g0_flat", 32'(clk_o[0]), 32'd0);
        chk("g0_others_run", 32'(clk_o[3:1]), 32'h7);

        // Level wake: clock back one edge after waking edge, ack two later
        req_i = 4'h1;
        tick();
        chk("w0_e0_ack", 32'(ack_o[0]), 32'd0);
        chk("w0_e0_clk", 32'(clk_o[0]), 32'd0);
        chk("w0_e0_gated", 32'(gated_o[0]), 32'd0);
        tick();
        chk("w0_e1_clk", 32'(clk_o[0]), 32'd1);
        chk("w0_e1_ack", 32'(ack_o[0]), 32'd0);
        tick();
        chk("w0_e2_ack", 32'(ack_o[0]), 32'd1);

        // Re-gate, then wake with a single-cycle req pulse
        req_i = 4'h0;
        repeat (4) tick();
        chk("p0_gated", 32'(gated_o[0]), 32'd1);
        req_i = 4'h1;
        tick();
        req_i = 4'h0; idle_i = 4'h0;
        chk("p0_e0_ack", 32'(ack_o[0]), 32'd0);
        tick();
        chk("p0_e1_ack", 32'(ack_o[0]), 32'd0);
        tick();
        chk("p0_e2_ack", 32'(ack_o[0]), 32'd1);

        // Ch2 gated, then test enable forces its clock
        idle_i = 4'h4;
        repeat (5) tick();
        chk("t2_gated", 32'(gated_o[2]), 32'd1);
        chk("t2_clk_off", 32'(clk_o[2]), 32'd0);
`ifdef CLOCK_GATE_ARRAY_STATS_EN
        stats_clr_i = 1'b1;
        tick();
        stats_clr_i = 1'b0;
        chk("st_clr", gated_cnt_o[2*32 +: 32], 32'd0);
        repeat (3) tick();
        chk("st_count3", gated_cnt_o[2*32 +: 32], 32'd3);
`endif
        te_i = 1'b1;
        #1;
        chk("t2_no_glitch_on", 32'(clk_o[2]), 32'd0);
        tick();
        chk("t2_te_clk", 32'(clk_o[2]), 32'd1);
        chk("t2_te_gated", 32'(gated_o[2]), 32'd1);
        chk("t2_te_ack", 32'(ack_o[2]), 32'd0);
        te_i = 1'b0;
        #1;
        chk("t2_no_glitch_off", 32'(clk_o[2]), 32'd1);
        @(negedge clk_i); #1;
        chk("t2_low_phase", 32'(clk_o[2]), 32'd0);
        tick();
        chk("t2_clk_stopped", 32'(clk_o[2]), 32'd0);

        // Reset lands while ch3 is in WAKE
        idle_i = 4'h8;
        repeat (5) tick();
        chk("r3_gated", 32'(gated_o[3]), 32'd1);
        req_i = 4'h8; idle_i = 4'h0;
        tick();
        chk("r3_wake_ack", 32'(ack_o[3]), 32'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("r3_async_ack", 32'(ack_o), 32'hF);
        chk("r3_async_gated", 32'(gated_o), 32'h0);
`ifdef CLOCK_GATE_ARRAY_STATS_EN
        chk("r3_stats_zero", gated_cnt_o[3*32 +: 32], 32'd0);
`endif
        tick();
        chk("r3_clk_running", 32'(clk_o), 32'hF);
        rst_i = 1'b0; req_i = 4'h0;
        tick();
        chk("r3_post_ack", 32'(ack_o), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
